instruction_memory: RTL
=======================

Name: instruction_memory

Overview:
- Instruction store on the consumer side of the program counter.
- Takes the PC address and returns the fetched 32-bit instruction with 1-cycle registered latency.
- Honours stall, halt and flush from the pipeline control.
- Has a byte-serial load port: the debug unit streams the program in 8-bit bytes, which are packed into words and written sequentially from address 0.

Parameters:
- NB_WIDTH, 32, instruction / address width.
- NB_DATA, 8, load-port byte width.
- MEM_DEPTH, 256, number of 32-bit words (power of 2); NB_IDX = clog2(MEM_DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_pcounter  in  NB_WIDTH  fetch byte address from program counter
- i_stall  in  1  hold fetch output (load-use hazard)
- i_halt  in  1  hold fetch output (processor halted)
- i_flush  in  1  replace fetched instruction with NOP (taken jump/branch)
- i_load_valid  in  1  i_load_byte valid this cycle
- i_load_byte  in  NB_DATA  program byte, big-endian order (first byte -> [31:24])
- i_load_clear  in  1  restart loader at word 0
- o_instruction  out  NB_WIDTH  registered fetched instruction
- o_addr_err  out  1  registered: last fetch misaligned or out of range
- o_words_loaded  out  NB_IDX+1  words written since reset/clear
- o_load_full  out  1  memory full, further bytes ignored
- o_halt_detected  out  1  see Optional Feature

Behaviour:
- Reset, asynchronous on i_rst_n low: o_instruction=0 (NOP), o_addr_err=0, o_words_loaded=0, o_load_full=0, byte counter=0, o_halt_detected=0. Memory array is not reset.
- Fetch index = i_pcounter[NB_IDX+1:2]. Latency: address presented in cycle N appears on o_instruction after the rising edge ending N.
- Fetch priority per edge:
  1. i_flush: o_instruction<=0, o_addr_err<=0 (wins over stall/halt).
  2. i_stall|i_halt: o_instruction and o_addr_err hold.
  3. Else if i_pcounter[1:0]!=0 or i_pcounter>=MEM_DEPTH*4: o_instruction<=0, o_addr_err<=1.
  4. Else o_instruction<=mem[index], o_addr_err<=0.
- Loader:
  - 2-bit byte counter; each i_load_valid shifts the byte into a 32-bit assembly register.
  - On the 4th byte, write the full word to mem[o_words_loaded[NB_IDX-1:0]], increment o_words_loaded, byte counter -> 0.
  - When o_words_loaded reaches MEM_DEPTH, o_load_full<=1 in the same edge. While full, i_load_valid is ignored; counter and contents unchanged.
  - i_load_clear: counter, o_words_loaded, o_load_full -> 0; partial word discarded; memory contents kept. Clear with simultaneous i_load_valid: clear wins, byte dropped.
- Read and write to the same word in the same cycle: fetch returns the old contents (read-before-write).
- Loading is independent of i_stall/i_halt/i_flush.
- Reset asserted mid-word: partial word lost; words already written stay in memory.

Optional Feature:
- Macro IMEM_HALT_DETECT_EN.
- Defined:
  - o_halt_detected set on the edge where a fetch (priority 4) returns 32'hFFFFFFFF.
  - Sticky until reset or i_load_clear.
  - Flushed, stalled or errored fetches never set it.
- Undefined: o_halt_detected tied to 0, no detection logic; port still present.

Test Plan:
- Reset, then load bytes 20,08,00,05 (x2 words: 2008000520090007) -> o_words_loaded=2; PC=0 then 4 -> o_instruction=20080005 then 20090007, one cycle after each PC.
- i_stall=1 with PC stepping 0->4 -> o_instruction holds 20080005; stall released -> 20090007 next edge. Repeat with i_halt, same result.
- i_flush=1 together with i_stall=1, PC=4 -> o_instruction=00000000, o_addr_err=0.
- PC=0x2 -> o_instruction=0, o_addr_err=1; PC=MEM_DEPTH*4 (0x400) -> o_addr_err=1; PC=0 -> o_addr_err=0.
- Load MEM_DEPTH words -> o_load_full=1, o_words_loaded=256; one extra word -> word 0 unchanged. i_load_clear with simultaneous byte -> counts 0, full 0.
- With IMEM_HALT_DETECT_EN: load FFFFFFFF at word 2, fetch PC=8 -> o_halt_detected=1 and stays 1; i_load_clear -> 0. Without the macro -> stays 0.

Source files
------------

// File: rtl/instruction_memory_if.sv
//------------------------------------------------------------------------------
// Module      : instruction_memory_if
// Description : Fetch and byte-serial load bus for instruction_memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instruction_memory_if #(
    parameter int NB_WIDTH  = 32,
    parameter int NB_DATA   = 8,
    parameter int MEM_DEPTH = 256,
    parameter int NB_IDX    = $clog2(MEM_DEPTH)
);
    logic [NB_WIDTH-1:0] i_pcounter;
    logic                i_stall;
    logic                i_halt;
    logic                i_flush;
    logic                i_load_valid;
    logic [NB_DATA-1:0]  i_load_byte;
    logic                i_load_clear;
    logic [NB_WIDTH-1:0] o_instruction;
    logic                o_addr_err;
    logic [NB_IDX:0]     o_words_loaded;
    logic                o_load_full;
    logic                o_halt_detected;

    modport master (
        output i_pcounter, i_stall, i_halt, i_flush,
        output i_load_valid, i_load_byte, i_load_clear,
        input  o_instruction, o_addr_err, o_words_loaded, o_load_full, o_halt_detected
    );

    modport slave (
        input  i_pcounter, i_stall, i_halt, i_flush,
        input  i_load_valid, i_load_byte, i_load_clear,
        output o_instruction, o_addr_err, o_words_loaded, o_load_full, o_halt_detected
    );
endinterface

`default_nettype wire

// File: rtl/instruction_memory.sv
//------------------------------------------------------------------------------
// Module      : instruction_memory
// Description : Word-addressed instruction store with registered fetch and a
//               byte-serial program loader. Optional IMEM_HALT_DETECT_EN flags
//               a fetched all-ones instruction.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instruction_memory #(
    parameter int NB_WIDTH  = 32,
    parameter int NB_DATA   = 8,
    parameter int MEM_DEPTH = 256
) (
    input wire            clk,
    input wire            i_rst_n,
    instruction_memory_if.slave bus
);
    localparam int NB_IDX = $clog2(MEM_DEPTH);
    localparam int NB_ASM = NB_WIDTH - NB_DATA;

    localparam logic [NB_WIDTH:0] c_BYTE_LIMIT = (NB_WIDTH+1)'(MEM_DEPTH * 4);
    localparam logic [NB_IDX:0]   c_FULL_COUNT = (NB_IDX+1)'(MEM_DEPTH);
    localparam logic [NB_IDX:0]   c_WORD_INC   = (NB_IDX+1)'(1);
    localparam logic [1:0]        c_LAST_BYTE  = 2'd3;

    logic [NB_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [NB_WIDTH-1:0] r_instruction;
    logic                r_addr_err;
    logic [NB_IDX:0]     r_words_loaded;
    logic                r_load_full;
    logic [1:0]          r_byte_cnt;
    logic [NB_ASM-1:0]   r_assembly;

    logic [NB_IDX-1:0]   w_fetch_idx;
    logic [NB_WIDTH-1:0] w_fetch_word;
    logic                w_fetch_bad;
    logic                w_fetch_hold;
    logic                w_fetch_normal;
    logic [NB_WIDTH-1:0] w_load_word;
    logic                w_byte_accept;
    logic                w_word_done;
    logic [NB_IDX:0]     w_words_next;

    assign w_fetch_idx    = bus.i_pcounter[NB_IDX+1:2];
    assign w_fetch_word   = r_mem[w_fetch_idx];
    assign w_fetch_bad    = (|bus.i_pcounter[1:0]) || ({1'b0, bus.i_pcounter} >= c_BYTE_LIMIT);
    assign w_fetch_hold   = bus.i_stall | bus.i_halt;
    assign w_fetch_normal = ~bus.i_flush & ~w_fetch_hold & ~w_fetch_bad;

    // Big-endian packing: earlier bytes have already been shifted upward.
    assign w_load_word   = {r_assembly, bus.i_load_byte};
    assign w_byte_accept = bus.i_load_valid & ~bus.i_load_clear & ~r_load_full;
    assign w_word_done   = w_byte_accept & (r_byte_cnt == c_LAST_BYTE);
    assign w_words_next  = r_words_loaded + c_WORD_INC;

    // No reset on the array so that program contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (w_word_done) begin
            r_mem[r_words_loaded[NB_IDX-1:0]] <= w_load_word;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instruction <= '0;
            r_addr_err    <= 1'b0;
        end else if (bus.i_flush) begin
            r_instruction <= '0;
            r_addr_err    <= 1'b0;
        end else if (w_fetch_hold) begin
            r_instruction <= r_instruction;
            r_addr_err    <= r_addr_err;
        end else if (w_fetch_bad) begin
            r_instruction <= '0;
            r_addr_err    <= 1'b1;
        end else begin
            r_instruction <= w_fetch_word;
            r_addr_err    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt     <= 2'd0;
            r_assembly     <= '0;
            r_words_loaded <= '0;
            r_load_full    <= 1'b0;
        end else if (bus.i_load_clear) begin
            r_byte_cnt     <= 2'd0;
            r_words_loaded <= '0;
            r_load_full    <= 1'b0;
        end else if (w_byte_accept) begin
            r_assembly <= w_load_word[NB_ASM-1:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_word_done) begin
                r_words_loaded <= w_words_next;
                if (w_words_next == c_FULL_COUNT) begin
                    r_load_full <= 1'b1;
                end
            end
        end
    end

`ifdef IMEM_HALT_DETECT_EN
    logic r_halt_detected;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_halt_detected <= 1'b0;
        end else if (bus.i_load_clear) begin
            r_halt_detected <= 1'b0;
        end else if (w_fetch_normal && (&w_fetch_word)) begin
            r_halt_detected <= 1'b1;
        end
    end

    assign bus.o_halt_detected = r_halt_detected;
`else
    logic w_unused_fetch_normal;
    assign w_unused_fetch_normal = w_fetch_normal;
    assign bus.o_halt_detected   = 1'b0;
`endif

    assign bus.o_instruction  = r_instruction;
    assign bus.o_addr_err     = r_addr_err;
    assign bus.o_words_loaded = r_words_loaded;
    assign bus.o_load_full    = r_load_full;

endmodule

`default_nettype wire
